// File: rtl/riscv_v_twos_comp_pipe.sv
// Pipelined conditional two's-complement (negate) of 8/16/32/64-bit vector elements.
// Optional build macro RISCV_V_TWOS_COMP_SAT_EN clamps overflowing elements to max positive.
module riscv_v_twos_comp_pipe #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_complement,
    input  logic [3:0]              in_osize,   // osize_vector_t, one-hot {64,32,16,8}
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_ovf
);

    localparam int NUM_BYTES       = DATA_WIDTH / 8;
    localparam int NUM_LANES       = DATA_WIDTH / 64;
    localparam int BYTES_PER_STAGE = 8 / NUM_STAGES;

    // Valid/ready: a beat moves on valid & ready at a rising edge. The pipe advances
    // whenever the output register is empty or being drained; otherwise every stage holds.
    logic advance;

    logic [DATA_WIDTH-1:0] s0_x;
    logic [NUM_BYTES-1:0]  s0_c;
    logic [NUM_BYTES-1:0]  s0_start;
    logic [NUM_BYTES-1:0]  s0_ovf;

    function automatic logic [DATA_WIDTH-1:0] resolve_data(
        input int                    s,
        input logic [DATA_WIDTH-1:0] x,
        input logic [NUM_BYTES-1:0]  c,
        input logic [NUM_BYTES-1:0]  start,
        input logic [NUM_LANES-1:0]  cin
    );
        logic [DATA_WIDTH-1:0] r;
        logic run;
        logic ci;
        int   p;
        r = x;
        for (int l = 0; l < NUM_LANES; l++) begin
            run = cin[l];
            for (int j = 0; j < BYTES_PER_STAGE; j++) begin
                p = l * 8 + s * BYTES_PER_STAGE + j;
                ci = start[p] ? c[p] : run;
                r[p*8 +: 8] = x[p*8 +: 8] + {7'd0, ci};
                run = ci & (x[p*8 +: 8] == 8'hFF);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_LANES-1:0] resolve_carry(
        input int                    s,
        input logic [DATA_WIDTH-1:0] x,
        input logic [NUM_BYTES-1:0]  c,
        input logic [NUM_BYTES-1:0]  start,
        input logic [NUM_LANES-1:0]  cin
    );
        logic [NUM_LANES-1:0] co;
        logic run;
        logic ci;
        int   p;
        co = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            run = cin[l];
            for (int j = 0; j < BYTES_PER_STAGE; j++) begin
                p = l * 8 + s * BYTES_PER_STAGE + j;
                ci = start[p] ? c[p] : run;
                run = ci & (x[p*8 +: 8] == 8'hFF);
            end
            co[l] = run;
        end
        return co;
    endfunction

    // Element decode, inversion and most-negative detection all happen before the first register.
    always_comb begin
        int   sz;
        int   base;
        int   top;
        logic mn;
        s0_x     = '0;
        s0_c     = '0;
        s0_start = '0;
        s0_ovf   = '0;
        case (in_osize)
            4'b0010: sz = 1;
            4'b0100: sz = 2;
            4'b1000: sz = 3;
            default: sz = 0;
        endcase
        for (int p = 0; p < NUM_BYTES; p++) begin
            base = (p >> sz) << sz;
            top  = base + (1 << sz) - 1;
            s0_start[p]    = (p == base);
            s0_c[p]        = in_complement[base];
            s0_x[p*8 +: 8] = in_data[p*8 +: 8] ^ {8{in_complement[base]}};
            mn = (in_data[top*8 +: 8] == 8'h80);
            for (int q = 0; q < 7; q++) begin
                if ((base + q < top) && (in_data[(base+q)*8 +: 8] != 8'h00)) mn = 1'b0;
            end
            s0_ovf[p] = in_complement[base] & mn;
        end
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic                  v_in;
        logic [DATA_WIDTH-1:0] x_in;
        logic [NUM_BYTES-1:0]  c_in;
        logic [NUM_BYTES-1:0]  start_in;
        logic [NUM_BYTES-1:0]  ovf_in;
        logic [NUM_LANES-1:0]  cy_in;
        logic [DATA_WIDTH-1:0] d_nx;
        logic [DATA_WIDTH-1:0] d_fin;
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_data;
        logic [NUM_BYTES-1:0]  r_ovf;

        if (s == 0) begin : g_src
            assign v_in     = in_valid;
            assign x_in     = s0_x;
            assign c_in     = s0_c;
            assign start_in = s0_start;
            assign ovf_in   = s0_ovf;
            assign cy_in    = '0;
        end else begin : g_src
            assign v_in     = g_stage[s-1].r_valid;
            assign x_in     = g_stage[s-1].r_data;
            assign c_in     = g_stage[s-1].g_fwd.r_c;
            assign start_in = g_stage[s-1].g_fwd.r_start;
            assign ovf_in   = g_stage[s-1].r_ovf;
            assign cy_in    = g_stage[s-1].g_fwd.r_carry;
        end

        assign d_nx = resolve_data(s, x_in, c_in, start_in, cy_in);

        if (s == NUM_STAGES - 1) begin : g_last
`ifdef RISCV_V_TWOS_COMP_SAT_EN
            // Wrapped most-negative inverted bytewise is exactly max positive.
            always_comb begin
                d_fin = d_nx;
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (ovf_in[b]) d_fin[b*8 +: 8] = ~d_nx[b*8 +: 8];
                end
            end
`else
            assign d_fin = d_nx;
`endif
        end else begin : g_fwd
            logic [NUM_BYTES-1:0] r_c;
            logic [NUM_BYTES-1:0] r_start;
            logic [NUM_LANES-1:0] r_carry;

            assign d_fin = d_nx;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_c     <= '0;
                    r_start <= '0;
                    r_carry <= '0;
                end else if (advance) begin
                    r_c     <= c_in;
                    r_start <= start_in;
                    r_carry <= resolve_carry(s, x_in, c_in, start_in, cy_in);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_ovf   <= '0;
            end else if (advance) begin
                r_valid <= v_in;
                r_data  <= d_fin;
                r_ovf   <= ovf_in;
            end
        end
    end

    assign out_valid = g_stage[NUM_STAGES-1].r_valid;
    assign out_data  = g_stage[NUM_STAGES-1].r_data;
    assign out_ovf   = g_stage[NUM_STAGES-1].r_ovf;

endmodule

// File: tb/tb_riscv_v_twos_comp_pipe.sv
// Self-checking bench for riscv_v_twos_comp_pipe: directed scenarios plus a scoreboard
// fed by an arithmetic reference model (honours RISCV_V_TWOS_COMP_SAT_EN).
module tb_riscv_v_twos_comp_pipe;

    localparam int DW = 128;
    localparam int NB = DW / 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NB-1:0] in_complement;
    logic [3:0]    in_osize;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NB-1:0] out_ovf;

    int checks    = 0;
    int errors    = 0;
    int out_count = 0;

    logic [DW-1:0] exp_q[$];
    logic [NB-1:0] exp_ovf_q[$];

    bit            stall_prev = 0;
    logic [DW-1:0] stall_data;
    logic [NB-1:0] stall_ovf;

    riscv_v_twos_comp_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_complement (in_complement),
        .in_osize      (in_osize),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ovf       (out_ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [DW-1:0] d, input logic [NB-1:0] c,
                                  input logic [3:0] os, output logic [DW-1:0] r,
                                  output logic [NB-1:0] ov);
        int eb;
        int w;
        case (os)
            4'b0010: eb = 2;
            4'b0100: eb = 4;
            4'b1000: eb = 8;
            default: eb = 1;
        endcase
        w  = eb * 8;
        r  = '0;
        ov = '0;
        for (int b = 0; b < NB; b += eb) begin
            logic [63:0] mask;
            logic [63:0] v;
            logic [63:0] mn;
            logic [63:0] res;
            logic        o;
            mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
            v    = 64'(d >> (b * 8)) & mask;
            mn   = 64'd1 << (w - 1);
            res  = c[b] ? ((~v + 64'd1) & mask) : v;
            o    = c[b] && (v == mn);
`ifdef RISCV_V_TWOS_COMP_SAT_EN
            if (o) res = mn - 64'd1;
`endif
            for (int k = 0; k < eb; k++) begin
                r[(b+k)*8 +: 8] = res[k*8 +: 8];
                ov[b+k]         = o;
            end
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rand_osize();
        case ($urandom_range(0, 4))
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            3:       return 4'b1000;
            default: return 4'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [DW-1:0] ed;
        logic [NB-1:0] eo;
        if (rst) begin
            exp_q.delete();
            exp_ovf_q.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== stall_data || out_ovf !== stall_ovf) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h o=%h want v=1 d=%h o=%h",
                             out_valid, out_data, out_ovf, stall_data, stall_ovf);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                out_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got d=%h o=%h want no beat", out_data, out_ovf);
                end else begin
                    ed = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    if (out_data !== ed || out_ovf !== eo) begin
                        errors++;
                        $display("FAIL scoreboard: got d=%h o=%h want d=%h o=%h",
                                 out_data, out_ovf, ed, eo);
                    end
                end
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            stall_data = out_data;
            stall_ovf  = out_ovf;
            if (in_valid && in_ready === 1'b1) begin
                model(in_data, in_complement, in_osize, ed, eo);
                exp_q.push_back(ed);
                exp_ovf_q.push_back(eo);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] d, input logic [NB-1:0] c, input logic [3:0] os);
        bit accepted;
        accepted      = 0;
        in_data       = d;
        in_complement = c;
        in_osize      = os;
        in_valid      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                accepted = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles want 1");
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_complement = '0;
        in_osize      = 4'b0001;
        out_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0 || out_ovf !== '0) begin
            errors++; $display("FAIL reset_out_data: got d=%h o=%h want 0", out_data, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bytes_latency();
        logic [DW-1:0] d;
        logic [31:0]   exp_lo;
        d = '0;
        d[31:0] = 32'h7F00_8001;
`ifdef RISCV_V_TWOS_COMP_SAT_EN
        exp_lo = 32'h8100_7FFF;
`else
        exp_lo = 32'h8100_80FF;
`endif
        out_ready = 1'b1;
        send(d, '1, 4'b0001);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t1_latency_early: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL t1_latency: got out_valid=%b want 1", out_valid);
        end
        checks++;
        if (out_data !== {96'd0, exp_lo} || out_ovf !== 16'h0002) begin
            errors++;
            $display("FAIL t1_bytes: got d=%h o=%h want d=%h o=0002", out_data, out_ovf, {96'd0, exp_lo});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dword_carry();
        bit          ok;
        logic [63:0] exp_hi;
`ifdef RISCV_V_TWOS_COMP_SAT_EN
        exp_hi = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_hi = 64'h8000_0000_0000_0000;
`endif
        out_ready = 1'b1;
        send({64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001}, '1, 4'b1000);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== {exp_hi, 64'hFFFF_FFFF_FFFF_FFFF} || out_ovf !== 16'hFF00) begin
            errors++;
            $display("FAIL t2_neg_one: got v=%b d=%h o=%h want d=%h o=ff00",
                     out_valid, out_data, out_ovf, {exp_hi, 64'hFFFF_FFFF_FFFF_FFFF});
        end
        @(posedge clk);
        #1;
        send({64'h0000_0000_0000_0100, 64'h0000_0001_0000_0000}, 16'h0101, 4'b1000);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== {64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_0000_0000} || out_ovf !== '0) begin
            errors++;
            $display("FAIL t2_stage_carry: got v=%b d=%h o=%h want d=ffffffffffffff00ffffffff00000000 o=0000",
                     out_valid, out_data, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_half_mixed();
        bit            ok;
        logic [DW-1:0] d;
        d = '0;
        d[47:0] = 48'h8000_0100_00FF;
        out_ready = 1'b1;
        send(d, 16'h0009, 4'b0010);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== {80'd0, 48'h8000_0100_FF01} || out_ovf !== '0) begin
            errors++;
            $display("FAIL t3_half_mixed: got v=%b d=%h o=%h want d=%h o=0000",
                     out_valid, out_data, out_ovf, {80'd0, 48'h8000_0100_FF01});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int start_count;
        start_count = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), rand_osize());
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    out_ready = (i % 4 == 0) || (i % 4 == 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        checks++;
        if (out_count - start_count != 8) begin
            errors++;
            $display("FAIL t4_count: got %0d results want 8", out_count - start_count);
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        bit leaked;
        out_ready = 1'b0;
        send(128'h11, '1, 4'b0001);
        send(128'h22, '1, 4'b0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t5_flush: got out_valid=%b want 0", out_valid);
        end
        leaked = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) leaked = 1;
        end
        checks++;
        if (leaked) begin
            errors++; $display("FAIL t5_no_ghost: got out_valid=1 after reset want 0");
        end
        @(posedge clk);
        #1;
        send(128'h5, 16'h0001, 4'b0100);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== {96'd0, 32'hFFFF_FFFB} || out_ovf !== '0) begin
            errors++;
            $display("FAIL t5_after_reset: got v=%b d=%h o=%h want d=%h o=0000",
                     out_valid, out_data, out_ovf, {96'd0, 32'hFFFF_FFFB});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit done;
        done = 0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [DW-1:0] d;
                    for (int b = 0; b < NB; b++) d[b*8 +: 8] = rand_byte();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(d, 16'($urandom), rand_osize());
                end
                done = 1;
            end
            begin
                for (int i = 0; i < 2000 && !done; i++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_bytes_latency();
        test_dword_carry();
        test_half_mixed();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
